// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of the producer-side and FIFO-side signals around the write-port
// arbiter. The arbiter connects through the slave modport, the producers and
// FIFO model through master, and passive observers through monitor.
interface fifo_wr_arbiter_if #(
    parameter int DWIDTH = 8,
    parameter int NREQ   = 4,
    parameter int IDW    = 2
);
    logic [NREQ-1:0]        in_valid;
    logic [NREQ*DWIDTH-1:0] in_data;
    logic [NREQ-1:0]        in_last;
    logic [NREQ-1:0]        in_ready;
    logic                   fifo_full;
    logic                   fifo_write;
    logic [DWIDTH-1:0]      fifo_datain;
    logic [IDW-1:0]         grant_id;
    logic                   busy;

    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, fifo_write, fifo_datain, grant_id, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, fifo_write, fifo_datain, grant_id, busy
    );

    modport monitor (
        input in_valid, in_data, in_last, fifo_full,
        input in_ready, fifo_write, fifo_datain, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one dcfifo write port among NREQ producers.
// A grant lasts at most MAX_BURST accepted words, ends early on in_last or
// when the owner stops presenting data, and is always followed by one IDLE
// bubble. Words pass straight through to the FIFO on the accepting edge;
// nothing is written while the FIFO reports full.
module fifo_wr_arbiter #(
    parameter int DWIDTH    = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IDW       = 2
) (
    input  logic              clk,
    input  logic              areset_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  last_q,  last_d;
    logic [CW-1:0]   cnt_q,   cnt_d;

    logic              busy_s;
    logic              owner_valid_s;
    logic              owner_last_s;
    logic [DWIDTH-1:0] owner_data_s;
    logic              accept_s;
    logic [IDW:0]      pick_s;
    logic [NREQ-1:0]   ready_s;

    // Round-robin search: the first requester after 'last', wrapping modulo
    // NREQ, so the previous owner is checked last. MSB of the result flags
    // that some requester was found.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  last);
        logic [IDW:0] res;
        int           idx;
        res = {(IDW+1){1'b0}};
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (req[idx]) begin
                res = {1'b1, IDW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign busy_s        = (state_q == ST_GRANT);
    assign owner_valid_s = bus.in_valid[grant_q];
    assign owner_last_s  = bus.in_last[grant_q];
    assign owner_data_s  = bus.in_data[grant_q*DWIDTH +: DWIDTH];
    assign accept_s      = busy_s & owner_valid_s & ~bus.fifo_full;
    assign pick_s        = rr_pick(bus.in_valid, last_q);

    // Only the owner is offered ready, and only while the FIFO has room.
    always_comb begin
        ready_s = {NREQ{1'b0}};
        if (busy_s && !bus.fifo_full) begin
            ready_s[grant_q] = 1'b1;
        end else begin
            ready_s = {NREQ{1'b0}};
        end
    end

    assign bus.in_ready    = ready_s;
    assign bus.fifo_write  = accept_s;
    assign bus.fifo_datain = busy_s ? owner_data_s : {DWIDTH{1'b0}};
    assign bus.busy        = busy_s;
    assign bus.grant_id    = grant_q;

    // Next-state logic: grant selection in IDLE, burst counting and release in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_s[IDW]) begin
                    state_d = ST_GRANT;
                    grant_d = pick_s[IDW-1:0];
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_valid_s) begin
                    // Owner went quiet (also while full): hand the port back.
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                    cnt_d   = {CW{1'b0}};
                end else if (accept_s) begin
                    if (owner_last_s || (cnt_q == CNT_LIMIT)) begin
                        // End of packet and burst limit on one word give one release.
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // FIFO full with owner still valid: hold grant and count.
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {IDW{1'b0}};
                last_d  = LAST_RST;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Owner state registers; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            grant_q <= {IDW{1'b0}};
            last_q  <= LAST_RST;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// Protocol checker for the arbiter: never write into a full FIFO, and never
// offer ready to more than one producer.
module fifo_wr_arbiter_chk (
    input  logic                clk,
    input  logic                areset_n,
    fifo_wr_arbiter_if.monitor  bus
);

    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!areset_n) !(bus.fifo_write && bus.fifo_full));

    a_ready_onehot0: assert property (
        @(posedge clk) disable iff (!areset_n) $onehot0(bus.in_ready));

endmodule
